// File: rtl/weather_pkg.sv
// Shared types and constants for the weather-station sensor readers.
package weather_pkg;

  typedef enum logic [2:0] {N, NE, E, SE, S, SW, W, NW} compass_t;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD, DONE} vane_state_t;

  localparam int ADC_BITS        = 10;
  localparam int NULL_EDGE       = 3;
  localparam int DATA_FIRST_EDGE = 4;

  // Eight equal sectors: the top three bits of the conversion.
  function automatic compass_t raw_to_dir(input logic [ADC_BITS-1:0] raw);
    return compass_t'(raw[ADC_BITS-1 -: 3]);
  endfunction

endpackage

// File: rtl/vane_spi_timer.sv
// Half-period counter and SPICLK rising-edge counter for the vane ADC reader.
module vane_spi_timer #(
  parameter int CLK_HALF   = 4,
  parameter int FRAME_BITS = 16,
  parameter int EW         = $clog2(FRAME_BITS + 1)
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          active,
  input  logic          rise,
  output logic          phase_done,
  output logic [EW-1:0] edge_num,
  output logic          last_edge
);

  localparam int HW = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;

  logic [HW-1:0] hcnt;
  logic [EW-1:0] edge_cnt;

  // Every active phase is exactly CLK_HALF long, so the counter simply wraps.
  assign phase_done = active && (hcnt == HW'(CLK_HALF - 1));
  assign edge_num   = edge_cnt + EW'(1);
  assign last_edge  = (edge_cnt == EW'(FRAME_BITS));

  always_ff @(posedge Clock) begin
    if (Reset || !active) begin
      hcnt     <= '0;
      edge_cnt <= '0;
    end else begin
      hcnt <= phase_done ? '0 : hcnt + HW'(1);
      if (rise) edge_cnt <= edge_cnt + EW'(1);
    end
  end

endmodule

// File: rtl/vane_adc_reader.sv
// SPI master for the 10-bit wind-vane ADC: one frame per start, result decoded to 8 sectors.
// Optional VANE_DEBOUNCE_EN: direction only changes after two matching good frames.
module vane_adc_reader
  import weather_pkg::*;
#(
  parameter int CLK_HALF   = 4,
  parameter int FRAME_BITS = 16
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       start,
  input  logic       MISO,
  output logic       SPICLK,
  output logic       nVaneCS,
  output logic       busy,
  output logic [9:0] vane_raw,
  output logic [2:0] vane_dir,
  output logic       vane_valid,
  output logic       vane_err
);

  localparam int EW = $clog2(FRAME_BITS + 1);

  vane_state_t           state, state_nxt;
  logic                  phase_done, last_edge, rise, active;
  logic [EW-1:0]         edge_num;
  logic [ADC_BITS-1:0]   shreg;
  logic                  null_bit;
  compass_t              dir_q;
  logic                  frame_end;

  vane_spi_timer #(.CLK_HALF(CLK_HALF), .FRAME_BITS(FRAME_BITS), .EW(EW)) u_timer (
    .Clock      (Clock),
    .Reset      (Reset),
    .active     (active),
    .rise       (rise),
    .phase_done (phase_done),
    .edge_num   (edge_num),
    .last_edge  (last_edge)
  );

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    SPICLK     = 1'b1;
    nVaneCS    = 1'b0;
    busy       = 1'b1;
    vane_valid = 1'b0;
    active     = 1'b1;
    rise       = 1'b0;
    case (state)
      IDLE: begin
        nVaneCS = 1'b1;
        busy    = 1'b0;
        active  = 1'b0;
        if (start) state_nxt = SETUP;
      end
      SETUP:    if (phase_done) state_nxt = SHIFT_LO;
      SHIFT_LO: begin
        SPICLK = 1'b0;
        if (phase_done) begin
          rise      = 1'b1;
          state_nxt = SHIFT_HI;
        end
      end
      SHIFT_HI: if (phase_done) state_nxt = last_edge ? HOLD : SHIFT_LO;
      HOLD:     if (phase_done) state_nxt = DONE;
      DONE: begin
        nVaneCS    = 1'b1;
        vane_valid = 1'b1;
        active     = 1'b0;
        state_nxt  = IDLE;
      end
      default: begin
        active    = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Results are committed entering DONE so they are visible alongside vane_valid.
  assign frame_end = (state == HOLD) && phase_done;
  assign vane_dir  = dir_q;

`ifdef VANE_DEBOUNCE_EN
  compass_t cand;
  logic     cand_vld;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      shreg    <= '0;
      null_bit <= 1'b0;
      vane_raw <= '0;
      dir_q    <= N;
      vane_err <= 1'b0;
`ifdef VANE_DEBOUNCE_EN
      cand     <= N;
      cand_vld <= 1'b0;
`endif
    end else begin
      if (rise) begin
        if (edge_num == EW'(NULL_EDGE)) null_bit <= MISO;
        if (edge_num >= EW'(DATA_FIRST_EDGE) && edge_num < EW'(DATA_FIRST_EDGE + ADC_BITS))
          shreg <= {shreg[ADC_BITS-2:0], MISO};
      end
      if (frame_end) begin
        vane_err <= null_bit;
        if (!null_bit) begin
          vane_raw <= shreg;
`ifdef VANE_DEBOUNCE_EN
          if (cand_vld && raw_to_dir(shreg) == cand) dir_q <= cand;
          cand     <= raw_to_dir(shreg);
          cand_vld <= 1'b1;
`else
          dir_q    <= raw_to_dir(shreg);
`endif
        end
`ifdef VANE_DEBOUNCE_EN
        else begin
          cand     <= N;
          cand_vld <= 1'b0;
        end
`endif
      end
    end
  end

endmodule
